// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage RV32I pipeline: load-use stall, branch flush,
// ID operand forwarding selects and MEM store-data forwarding.
module hazard_ctrl #(
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [RW-1:0] rs1_ID,
  input  logic [RW-1:0] rs2_ID,
  input  logic [RW-1:0] rd_ID,
  input  logic          rs1use_ID,
  input  logic          rs2use_ID,
  input  logic [1:0]    optype_ID,
  input  logic          Branch_ID,
  input  logic          mem_stall,
  output logic          PC_EN_IF,
  output logic          reg_FD_EN,
  output logic          reg_FD_flush,
  output logic          reg_DE_EN,
  output logic          reg_DE_flush,
  output logic          reg_EM_EN,
  output logic          reg_MW_EN,
  output logic [1:0]    fwd_rs1,
  output logic [1:0]    fwd_rs2,
  output logic          fwd_ls
);

  localparam logic [1:0] OP_NONE  = 2'd0;
  localparam logic [1:0] OP_ALU   = 2'd1;
  localparam logic [1:0] OP_LOAD  = 2'd2;
  localparam logic [1:0] OP_STORE = 2'd3;

  logic [1:0]    r_optype_EX, r_optype_MEM, r_optype_WB;
  logic [RW-1:0] r_rd_EX, r_rd_MEM, r_rd_WB;
  logic [RW-1:0] r_rs2_EX, r_rs2_MEM;

  logic w_ex_rs1, w_ex_rs2, w_mem_rs1, w_mem_rs2;
  logic w_load_use;

  // x0 is hardwired, so a producer targeting it never matches a consumer.
  function automatic logic writes_reg(input logic [1:0] op, input logic [RW-1:0] rd,
                                      input logic [RW-1:0] r);
    return ((op == OP_ALU) || (op == OP_LOAD)) && (rd == r) && (r != '0);
  endfunction

  // An EX load hit selects the regfile: the load-use stall hides that cycle.
  function automatic logic [1:0] fwd_sel(input logic use_r, input logic ex_hit,
                                         input logic mem_hit, input logic [1:0] op_ex,
                                         input logic [1:0] op_mem);
    logic [1:0] sel;
    sel = 2'd0;
    if (use_r) begin
      if (ex_hit)       sel = (op_ex == OP_ALU) ? 2'd1 : 2'd0;
      else if (mem_hit) sel = (op_mem == OP_ALU) ? 2'd2 : 2'd3;
    end
    return sel;
  endfunction

  assign w_ex_rs1  = writes_reg(r_optype_EX,  r_rd_EX,  rs1_ID);
  assign w_ex_rs2  = writes_reg(r_optype_EX,  r_rd_EX,  rs2_ID);
  assign w_mem_rs1 = writes_reg(r_optype_MEM, r_rd_MEM, rs1_ID);
  assign w_mem_rs2 = writes_reg(r_optype_MEM, r_rd_MEM, rs2_ID);

  // Store data hazards on an EX load are patched in MEM through fwd_ls instead.
  assign w_load_use = (r_optype_EX == OP_LOAD) &&
                      ((rs1use_ID && w_ex_rs1) ||
                       (rs2use_ID && (optype_ID != OP_STORE) && w_ex_rs2));

  assign fwd_rs1 = fwd_sel(rs1use_ID, w_ex_rs1, w_mem_rs1, r_optype_EX, r_optype_MEM);
  assign fwd_rs2 = fwd_sel(rs2use_ID, w_ex_rs2, w_mem_rs2, r_optype_EX, r_optype_MEM);
  assign fwd_ls  = (r_optype_MEM == OP_STORE) && (r_optype_WB == OP_LOAD) &&
                   (r_rd_WB != '0) && (r_rd_WB == r_rs2_MEM);

  always_comb begin
    PC_EN_IF     = 1'b1;
    reg_FD_EN    = 1'b1;
    reg_FD_flush = 1'b0;
    reg_DE_EN    = 1'b1;
    reg_DE_flush = 1'b0;
    reg_EM_EN    = 1'b1;
    reg_MW_EN    = 1'b1;
    if (mem_stall) begin
      PC_EN_IF  = 1'b0;
      reg_FD_EN = 1'b0;
      reg_DE_EN = 1'b0;
      reg_EM_EN = 1'b0;
      reg_MW_EN = 1'b0;
    end else if (w_load_use) begin
      PC_EN_IF     = 1'b0;
      reg_FD_EN    = 1'b0;
      reg_DE_flush = 1'b1;
    end else begin
      reg_FD_flush = Branch_ID;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_optype_EX  <= OP_NONE;
      r_rd_EX      <= '0;
      r_rs2_EX     <= '0;
      r_optype_MEM <= OP_NONE;
      r_rd_MEM     <= '0;
      r_rs2_MEM    <= '0;
      r_optype_WB  <= OP_NONE;
      r_rd_WB      <= '0;
    end else if (!mem_stall) begin
      r_optype_MEM <= r_optype_EX;
      r_rd_MEM     <= r_rd_EX;
      r_rs2_MEM    <= r_rs2_EX;
      r_optype_WB  <= r_optype_MEM;
      r_rd_WB      <= r_rd_MEM;
      if (w_load_use) begin
        r_optype_EX <= OP_NONE;
        r_rd_EX     <= '0;
        r_rs2_EX    <= '0;
      end else begin
        r_optype_EX <= optype_ID;
        r_rd_EX     <= rd_ID;
        r_rs2_EX    <= rs2_ID;
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: each cycle drives one ID instruction and
// compares the packed control/forward outputs against hand-derived expectations.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] rs1_ID = '0, rs2_ID = '0, rd_ID = '0;
  logic       rs1use_ID = 1'b0, rs2use_ID = 1'b0;
  logic [1:0] optype_ID = 2'd0;
  logic       Branch_ID = 1'b0, mem_stall = 1'b0;
  logic       PC_EN_IF, reg_FD_EN, reg_FD_flush, reg_DE_EN, reg_DE_flush;
  logic       reg_EM_EN, reg_MW_EN, fwd_ls;
  logic [1:0] fwd_rs1, fwd_rs2;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       tag;
    logic [11:0] exp;
  } sb_t;
  sb_t sb[$];

  hazard_ctrl #(.RW(5)) dut (
    .clk(clk), .rst(rst),
    .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .rd_ID(rd_ID),
    .rs1use_ID(rs1use_ID), .rs2use_ID(rs2use_ID),
    .optype_ID(optype_ID), .Branch_ID(Branch_ID), .mem_stall(mem_stall),
    .PC_EN_IF(PC_EN_IF), .reg_FD_EN(reg_FD_EN), .reg_FD_flush(reg_FD_flush),
    .reg_DE_EN(reg_DE_EN), .reg_DE_flush(reg_DE_flush),
    .reg_EM_EN(reg_EM_EN), .reg_MW_EN(reg_MW_EN),
    .fwd_rs1(fwd_rs1), .fwd_rs2(fwd_rs2), .fwd_ls(fwd_ls)
  );

  always #5 clk = ~clk;

  // Packing: {PC_EN, FD_EN, FD_flush, DE_EN, DE_flush, EM_EN, MW_EN, fwd_rs1, fwd_rs2, fwd_ls}
  function automatic logic [11:0] e_run(input logic fdfl, input logic [1:0] f1,
                                        input logic [1:0] f2, input logic ls);
    return {1'b1, 1'b1, fdfl, 1'b1, 1'b0, 1'b1, 1'b1, f1, f2, ls};
  endfunction

  function automatic logic [11:0] e_lu(input logic [1:0] f1, input logic [1:0] f2,
                                       input logic ls);
    return {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, f1, f2, ls};
  endfunction

  function automatic logic [11:0] e_ms(input logic [1:0] f1, input logic [1:0] f2,
                                       input logic ls);
    return {7'b0, f1, f2, ls};
  endfunction

  task automatic check(input string tag, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", tag, act, exp);
    end
  endtask

  // Drive one ID-stage instruction after the rising edge, sample at the falling edge.
  task automatic step(input string tag, input logic r_v, input logic ms,
                      input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d,
                      input logic u1, input logic u2, input logic [1:0] op,
                      input logic br, input logic [11:0] exp);
    sb_t e;
    @(posedge clk);
    #1;
    rst       = r_v;
    mem_stall = ms;
    rs1_ID    = s1;
    rs2_ID    = s2;
    rd_ID     = d;
    rs1use_ID = u1;
    rs2use_ID = u2;
    optype_ID = op;
    Branch_ID = br;
    sb.push_back('{tag, exp});
    @(negedge clk);
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = sb.pop_front();
      check(e.tag, {PC_EN_IF, reg_FD_EN, reg_FD_flush, reg_DE_EN, reg_DE_flush,
                    reg_EM_EN, reg_MW_EN, fwd_rs1, fwd_rs2, fwd_ls}, e.exp);
    end
  endtask

  initial begin
    //        tag          rst ms  rs1 rs2 rd  u1 u2 op br expected
    step("reset",         1, 0, 0,  0,  0,  0, 0, 0, 0, e_run(0, 0, 0, 0));
    step("addi_x1",       0, 0, 0,  0,  1,  1, 0, 1, 0, e_run(0, 0, 0, 0));
    step("add_x2_ex_fwd", 0, 0, 1,  1,  2,  1, 1, 1, 0, e_run(0, 1, 1, 0));
    step("sub_x3_mem",    0, 0, 1,  0,  3,  1, 1, 1, 0, e_run(0, 2, 0, 0));
    step("lw_x5",         0, 0, 0,  0,  5,  1, 0, 2, 0, e_run(0, 0, 0, 0));
    step("add_x6_stall",  0, 0, 5,  0,  6,  1, 1, 1, 0, e_lu(0, 0, 0));
    step("add_x6_ldfwd",  0, 0, 5,  0,  6,  1, 1, 1, 0, e_run(0, 3, 0, 0));
    step("lw_x5_b",       0, 0, 0,  0,  5,  1, 0, 2, 0, e_run(0, 0, 0, 0));
    step("sw_x5_nostall", 0, 0, 0,  5,  4,  1, 1, 3, 0, e_run(0, 0, 0, 0));
    step("nop_a",         0, 0, 0,  0,  0,  0, 0, 0, 0, e_run(0, 0, 0, 0));
    step("fwd_ls",        0, 0, 0,  0,  0,  0, 0, 0, 0, e_run(0, 0, 0, 1));
    step("lw_x7",         0, 0, 0,  0,  7,  1, 0, 2, 0, e_run(0, 0, 0, 0));
    step("beq_stall",     0, 0, 7,  0,  8,  1, 1, 0, 1, e_lu(0, 0, 0));
    step("beq_flush",     0, 0, 7,  0,  8,  1, 1, 0, 1, e_run(1, 3, 0, 0));
    step("addi_x0",       0, 0, 0,  0,  0,  1, 0, 1, 0, e_run(0, 0, 0, 0));
    step("add_x2_x0",     0, 0, 0,  0,  2,  1, 1, 1, 0, e_run(0, 0, 0, 0));
    step("lw_x0",         0, 0, 0,  0,  0,  1, 0, 2, 0, e_run(0, 0, 0, 0));
    step("add_x3_x0_ld",  0, 0, 0,  0,  3,  1, 1, 1, 0, e_run(0, 0, 0, 0));
    for (int i = 0; i < 3; i++)
      step("memstall",    0, 1, 3,  2,  4,  1, 1, 1, 1, e_ms(1, 0, 0));
    step("after_memstall",0, 0, 3,  2,  4,  1, 1, 1, 0, e_run(0, 1, 0, 0));
    step("memstall_b",    0, 1, 4,  3,  5,  1, 1, 1, 0, e_ms(1, 2, 0));
    step("rst_midstall",  1, 0, 4,  3,  5,  1, 1, 1, 0, e_run(0, 0, 0, 0));
    step("post_rst",      0, 0, 4,  3,  5,  1, 1, 1, 0, e_run(0, 0, 0, 0));
    step("lw_x9",         0, 0, 0,  0,  9,  1, 0, 2, 0, e_run(0, 0, 0, 0));
    step("ms_over_lu",    0, 1, 1,  9, 10,  1, 1, 1, 0, e_ms(0, 0, 0));
    step("lu_rs2",        0, 0, 1,  9, 10,  1, 1, 1, 0, e_lu(0, 0, 0));
    step("lu_rs2_fwd",    0, 0, 1,  9, 10,  1, 1, 1, 0, e_run(0, 0, 3, 0));
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
